// File: rtl/merlin_int_wb_stage_if.sv
// merlin_int_wb_stage_if: writeback-stage bus bundling the execute/load-issue
// handshake, the LSU load-response handshake, both register-file write ports
// and the pending-load scoreboard.
//   slave  : the writeback stage's view (consumes exs/lsu, drives wreg/pending)
//   master : the surrounding pipeline's view (drives exs/lsu, observes the rest)
interface merlin_int_wb_stage_if #(parameter int RV_XLEN = 32);
  logic               exs_valid_i;
  logic               exs_ready_o;
  logic               exs_is_load_i;
  logic [4:0]         exs_rd_i;
  logic [RV_XLEN-1:0] exs_data_i;
  logic               lsu_rsp_valid_i;
  logic               lsu_rsp_ready_o;
  logic [4:0]         lsu_rsp_rd_i;
  logic [RV_XLEN-1:0] lsu_rsp_data_i;
  logic               wreg_a_wr_o;
  logic [4:0]         wreg_a_addr_o;
  logic [RV_XLEN-1:0] wreg_a_data_o;
  logic               wreg_b_wr_o;
  logic [4:0]         wreg_b_addr_o;
  logic [RV_XLEN-1:0] wreg_b_data_o;
  logic [31:0]        pending_o;
  modport slave (
    input  exs_valid_i, exs_is_load_i, exs_rd_i, exs_data_i,
    input  lsu_rsp_valid_i, lsu_rsp_rd_i, lsu_rsp_data_i,
    output exs_ready_o, lsu_rsp_ready_o,
    output wreg_a_wr_o, wreg_a_addr_o, wreg_a_data_o,
    output wreg_b_wr_o, wreg_b_addr_o, wreg_b_data_o,
    output pending_o
  );
  modport master (
    output exs_valid_i, exs_is_load_i, exs_rd_i, exs_data_i,
    output lsu_rsp_valid_i, lsu_rsp_rd_i, lsu_rsp_data_i,
    input  exs_ready_o, lsu_rsp_ready_o,
    input  wreg_a_wr_o, wreg_a_addr_o, wreg_a_data_o,
    input  wreg_b_wr_o, wreg_b_addr_o, wreg_b_data_o,
    input  pending_o
  );
endinterface

// File: rtl/merlin_int_wb_stage.sv
// merlin_int_wb_stage: integer writeback stage, sole driver of the register
// file's two write ports.
//   clk_i    : clock, all state on the rising edge
//   reset_i  : asynchronous active-low reset
//   wb       : slave side of merlin_int_wb_stage_if
//              port A <- execute results (latency 1)
//              port B <- LSU load data through a LQ_DEPTH-entry FIFO (latency 2)
//              pending_o = per-register outstanding-load scoreboard
// Optional: define MERLIN_WB_BYPASS_EN to let a response that finds the FIFO
// empty load the port B registers directly (latency 1).
module merlin_int_wb_stage #(
  parameter int LQ_DEPTH = 4,
  parameter int RV_XLEN  = 32
) (
  input logic                 clk_i,
  input logic                 reset_i,
  merlin_int_wb_stage_if.slave wb
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(LQ_DEPTH);
  logic               exs_fire, alu_fire, ld_fire, rsp_fire;
  logic               empty, full, pop, push, bypass, inc, dec;
  logic [CW-1:0]      out_q, out_d, cnt_q, cnt_d;
  logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [4:0]         mrd_q [LQ_DEPTH];
  logic [4:0]         mrd_d [LQ_DEPTH];
  logic [RV_XLEN-1:0] mdat_q [LQ_DEPTH];
  logic [RV_XLEN-1:0] mdat_d [LQ_DEPTH];
  logic               a_wr_q, a_wr_d, b_wr_q, b_wr_d;
  logic [4:0]         a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [RV_XLEN-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic [31:0]        pend_q, pend_d, set_m, clr_m;
  always_comb begin
    empty  = cnt_q == '0;
    full   = cnt_q == FULL;
    pop    = !empty;
    // the FIFO drains every cycle, so a full FIFO is always popping and can still accept
    wb.lsu_rsp_ready_o = reset_i & (!full | pop);
    // WAW stall against outstanding loads, plus the load credit limit
    wb.exs_ready_o = reset_i & !pend_q[wb.exs_rd_i] & !(wb.exs_is_load_i & out_q == FULL);
    exs_fire = wb.exs_valid_i & wb.exs_ready_o;
    alu_fire = exs_fire & !wb.exs_is_load_i;
    ld_fire  = exs_fire & wb.exs_is_load_i;
    rsp_fire = wb.lsu_rsp_valid_i & wb.lsu_rsp_ready_o;
`ifdef MERLIN_WB_BYPASS_EN
    bypass = rsp_fire & empty;
`else
    bypass = 1'b0;
`endif
    push   = rsp_fire & !bypass;
    mrd_d  = mrd_q;
    mdat_d = mdat_q;
    if (push) begin
      mrd_d[wp_q]  = wb.lsu_rsp_rd_i;
      mdat_d[wp_q] = wb.lsu_rsp_data_i;
    end
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    a_wr_d   = alu_fire & (wb.exs_rd_i != 5'd0);
    a_addr_d = alu_fire ? wb.exs_rd_i : 5'd0;
    a_data_d = alu_fire ? wb.exs_data_i : '0;
    b_wr_d   = pop ? mrd_q[rp_q] != 5'd0 : bypass & (wb.lsu_rsp_rd_i != 5'd0);
    b_addr_d = pop ? mrd_q[rp_q] : bypass ? wb.lsu_rsp_rd_i : 5'd0;
    b_data_d = pop ? mdat_q[rp_q] : bypass ? wb.lsu_rsp_data_i : '0;
    // a load retires from the counter when it enters the port B registers
    inc   = ld_fire;
    dec   = pop | bypass;
    out_d = (inc & !dec) ? out_q + CW'(1) :
            (dec & !inc & out_q != '0) ? out_q - CW'(1) : out_q;
    set_m  = ld_fire ? 32'd1 << wb.exs_rd_i : 32'd0;
    clr_m  = b_wr_q ? 32'd1 << b_addr_q : 32'd0;
    pend_d = (pend_q | set_m) & ~clr_m & ~32'd1;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_q    <= '0;
      cnt_q    <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      a_wr_q   <= 1'b0;
      a_addr_q <= '0;
      a_data_q <= '0;
      b_wr_q   <= 1'b0;
      b_addr_q <= '0;
      b_data_q <= '0;
      pend_q   <= '0;
      for (int i = 0; i < LQ_DEPTH; i++) begin
        mrd_q[i]  <= '0;
        mdat_q[i] <= '0;
      end
    end else begin
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      a_wr_q   <= a_wr_d;
      a_addr_q <= a_addr_d;
      a_data_q <= a_data_d;
      b_wr_q   <= b_wr_d;
      b_addr_q <= b_addr_d;
      b_data_q <= b_data_d;
      pend_q   <= pend_d;
      mrd_q    <= mrd_d;
      mdat_q   <= mdat_d;
    end
  end
  assign wb.wreg_a_wr_o   = a_wr_q;
  assign wb.wreg_a_addr_o = a_addr_q;
  assign wb.wreg_a_data_o = a_data_q;
  assign wb.wreg_b_wr_o   = b_wr_q;
  assign wb.wreg_b_addr_o = b_addr_q;
  assign wb.wreg_b_data_o = b_data_q;
  assign wb.pending_o     = pend_q;
endmodule
